multicycle_ctrl: RTL and testbench

Multicycle sequencer for the 16-bit CPU core. Steps each instruction through fetch/decode/execute/memory/writeback and shares one memory port between instruction fetch and data access. Drives the datapath strobes: PC/IR write, register write, memory request, ALU op and mux selects. Replaces the single-cycle combinational decode once the core moves to a unified memory.

---
 rtl/multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle sequencer for the 16-bit CPU core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB. One memory port
// is shared between instruction fetch and data access. A stalled memory
// request that exceeds MEM_TIMEOUT wait cycles parks the sequencer in ERR
// until reset.
// Optional feature macro: MULTICYCLE_RETIRE_CNT_EN adds the retire_cnt
// output, a CNT_W-bit count of completed instructions.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
`ifdef MULTICYCLE_RETIRE_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src,
  output logic [3:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       link_write,
  output logic       fault
`ifdef MULTICYCLE_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_LSL  = 4'd8;
  localparam logic [3:0] OP_LSR  = 4'd9;
  localparam logic [3:0] OP_LDR  = 4'd10;
  localparam logic [3:0] OP_STR  = 4'd11;
  localparam logic [3:0] OP_B    = 4'd12;
  localparam logic [3:0] OP_BL   = 4'd13;
  localparam logic [3:0] OP_BR   = 4'd14;
  localparam logic [3:0] OP_BEQ  = 4'd15;

  // Wide enough to hold MEM_TIMEOUT-1, the last count before the fault fires.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_op;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_waiting;
  logic              w_timeout;
  logic              w_is_ldr;
  logic              w_is_str;
  logic              w_alu_src;
  logic [3:0]        w_alu_op;

  assign w_is_ldr  = (r_op == OP_LDR);
  assign w_is_str  = (r_op == OP_STR);
  assign w_alu_src = (r_op == OP_ADDI) || w_is_ldr || w_is_str;
  assign w_waiting = ((r_state == FETCH) || (r_state == MEM)) && !mem_ready;
  // The current stalled cycle is the MEM_TIMEOUT-th in a row; a zero
  // MEM_TIMEOUT never fires.
  assign w_timeout = (MEM_TIMEOUT != 0) &&
                     (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  // ALU operation decoded from the latched opcode (memory ops use add, beq subtracts).
  always_comb begin
    w_alu_op = 4'b0000;
    case (r_op)
      OP_SUB:  w_alu_op = 4'b0001;
      OP_AND:  w_alu_op = 4'b0010;
      OP_OR:   w_alu_op = 4'b0100;
      OP_XOR:  w_alu_op = 4'b0110;
      OP_NOT:  w_alu_op = 4'b1110;
      OP_SLT:  w_alu_op = 4'b0111;
      OP_LSL:  w_alu_op = 4'b1100;
      OP_LSR:  w_alu_op = 4'b1000;
      OP_BEQ:  w_alu_op = 4'b0001;
      default: w_alu_op = 4'b0000;
    endcase
  end

  // State register, opcode latch and consecutive-wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_op       <= 4'd0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) begin
        r_op <= opcode;
      end
      if (w_waiting && (w_next == r_state)) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  // Next-state selection and Moore-style strobe decode for each state.
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 4'b0000;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    link_write = 1'b0;
    fault      = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = DECODE;
        end else if (w_timeout) begin
          w_next = ERR;
        end
      end
      DECODE: begin
        w_next = EXEC;
      end
      EXEC: begin
        alu_op  = w_alu_op;
        alu_src = w_alu_src;
        case (r_op)
          OP_LDR, OP_STR: begin
            w_next = MEM;
          end
          OP_B: begin
            pc_write = 1'b1;
            pc_src   = 2'b01;
            w_next   = FETCH;
          end
          OP_BL: begin
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            link_write = 1'b1;
            w_next     = FETCH;
          end
          OP_BR: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            w_next   = FETCH;
          end
          OP_BEQ: begin
            pc_write = zero;
            pc_src   = 2'b01;
            w_next   = FETCH;
          end
          default: begin
            w_next = WB;
          end
        endcase
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_sel   = 1'b1;
        mem_read  = w_is_ldr;
        mem_write = w_is_str;
        alu_op    = w_alu_op;
        alu_src   = w_alu_src;
        if (mem_ready) begin
          w_next = w_is_str ? FETCH : WB;
        end else if (w_timeout) begin
          w_next = ERR;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = w_is_ldr;
        reg_dst    = (r_op <= OP_LSR) && (r_op != OP_ADDI);
        w_next     = FETCH;
      end
      ERR: begin
        fault = 1'b1;
      end
      default: begin
        w_next = FETCH;
      end
    endcase
  end

`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_retire_cnt;

  // An instruction completes when it leaves WB, when a store leaves MEM,
  // or when a branch leaves EXEC.
  assign w_retire = (r_state == WB) ||
                    ((r_state == MEM) && mem_ready && w_is_str) ||
                    ((r_state == EXEC) && (r_op >= OP_B));

  // Free-running wrap-around count of completed instructions; ERR never retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl.
// The stimulus process drives one cycle at a time and queues the outputs
// expected in that cycle; an independent monitor pops and compares on the
// falling edge.
module tb_multicycle_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_sel;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       alu_src;
   logic [3:0] alu_op;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       link_write;
   logic       fault;
`ifdef MULTICYCLE_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
`endif

   typedef struct packed {
      logic       memReq;
      logic       memSel;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       pcWrite;
      logic [1:0] pcSrc;
      logic       aluSrc;
      logic [3:0] aluOp;
      logic       regDst;
      logic       memToReg;
      logic       regWrite;
      logic       linkWrite;
      logic       fault;
   } outs_t;

   typedef struct {
      string tag;
      outs_t outs;
      int    retire;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   expRetire = 0;

   multicycle_ctrl #(
      .MEM_TIMEOUT(15)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_sel    (mem_sel),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .alu_src    (alu_src),
      .alu_op     (alu_op),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .link_write (link_write),
      .fault      (fault)
`ifdef MULTICYCLE_RETIRE_CNT_EN
      ,
      .retire_cnt (retire_cnt)
`endif
   );

   // Free-running core clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // FETCH strobes: request/read always, IR and PC load only in the ready cycle.
   function automatic outs_t fetchOuts(input logic ready);
      outs_t o;
      o = '0;
      o.memReq  = 1'b1;
      o.memRead = 1'b1;
      o.irWrite = ready;
      o.pcWrite = ready;
      return o;
   endfunction

   // Drives one cycle's inputs just after the rising edge and queues the
   // outputs that must be visible during that cycle.
   task automatic applyStimulus(input string tag, input logic rstVal, input logic ready,
                                input logic [3:0] op, input logic z, input outs_t outs);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n     = rstVal;
      mem_ready = ready;
      opcode    = op;
      zero      = z;
      e.tag    = tag;
      e.outs   = outs;
      e.retire = expRetire;
      expQ.push_back(e);
   endtask

   // Compares one popped expectation against the live DUT outputs.
   task automatic checkOutput(input exp_t e);
      outs_t actual;
      actual = {mem_req, mem_sel, mem_read, mem_write, ir_write, pc_write, pc_src,
                alu_src, alu_op, reg_dst, mem_to_reg, reg_write, link_write, fault};
      checks++;
      if (actual !== e.outs) begin
         errors++;
         $display("[TB] FAIL %s outputs: got %b expected %b", e.tag, actual, e.outs);
      end
`ifdef MULTICYCLE_RETIRE_CNT_EN
      checks++;
      if (retire_cnt !== 16'(e.retire)) begin
         errors++;
         $display("[TB] FAIL %s retire_cnt: got %0d expected %0d", e.tag, retire_cnt, e.retire);
      end
`endif
   endtask

   // Monitor: on each falling edge, compare against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   task automatic fetchPhase(input string tag, input logic [3:0] op, input int waits, input logic z);
      for (int i = 0; i < waits; i++) begin
         applyStimulus({tag, "/fwait"}, 1'b1, 1'b0, op, z, fetchOuts(1'b0));
      end
      applyStimulus({tag, "/fetch"}, 1'b1, 1'b1, op, z, fetchOuts(1'b1));
   endtask

   task automatic runAlu(input string tag, input logic [3:0] op, input int fetchWaits,
                         input logic aluSrc, input logic [3:0] aluOp, input logic regDst);
      outs_t e;
      fetchPhase(tag, op, fetchWaits, 1'b0);
      applyStimulus({tag, "/dec"}, 1'b1, 1'b1, op, 1'b0, '0);
      e = '0;
      e.aluSrc = aluSrc;
      e.aluOp  = aluOp;
      applyStimulus({tag, "/exe"}, 1'b1, 1'b1, op, 1'b0, e);
      e = '0;
      e.regWrite = 1'b1;
      e.regDst   = regDst;
      applyStimulus({tag, "/wb"}, 1'b1, 1'b1, op, 1'b0, e);
      expRetire++;
   endtask

   task automatic runLdr(input string tag, input int memWaits);
      outs_t e;
      fetchPhase(tag, 4'd10, 0, 1'b0);
      applyStimulus({tag, "/dec"}, 1'b1, 1'b1, 4'd10, 1'b0, '0);
      e = '0;
      e.aluSrc = 1'b1;
      applyStimulus({tag, "/exe"}, 1'b1, 1'b1, 4'd10, 1'b0, e);
      e.memReq  = 1'b1;
      e.memSel  = 1'b1;
      e.memRead = 1'b1;
      for (int i = 0; i < memWaits; i++) begin
         applyStimulus({tag, "/mwait"}, 1'b1, 1'b0, 4'd10, 1'b0, e);
      end
      applyStimulus({tag, "/mem"}, 1'b1, 1'b1, 4'd10, 1'b0, e);
      e = '0;
      e.regWrite = 1'b1;
      e.memToReg = 1'b1;
      applyStimulus({tag, "/wb"}, 1'b1, 1'b1, 4'd10, 1'b0, e);
      expRetire++;
   endtask

   task automatic runStr(input string tag);
      outs_t e;
      fetchPhase(tag, 4'd11, 0, 1'b0);
      applyStimulus({tag, "/dec"}, 1'b1, 1'b1, 4'd11, 1'b0, '0);
      e = '0;
      e.aluSrc = 1'b1;
      applyStimulus({tag, "/exe"}, 1'b1, 1'b1, 4'd11, 1'b0, e);
      e.memReq   = 1'b1;
      e.memSel   = 1'b1;
      e.memWrite = 1'b1;
      applyStimulus({tag, "/mem"}, 1'b1, 1'b1, 4'd11, 1'b0, e);
      expRetire++;
   endtask

   task automatic runBranch(input string tag, input logic [3:0] op, input logic z,
                            input logic pcWrite, input logic [1:0] pcSrc,
                            input logic link, input logic [3:0] aluOp);
      outs_t e;
      fetchPhase(tag, op, 0, z);
      applyStimulus({tag, "/dec"}, 1'b1, 1'b1, op, z, '0);
      e = '0;
      e.pcWrite   = pcWrite;
      e.pcSrc     = pcSrc;
      e.linkWrite = link;
      e.aluOp     = aluOp;
      applyStimulus({tag, "/exe"}, 1'b1, 1'b1, op, z, e);
      expRetire++;
   endtask

   // Directed sequence: every instruction class, memory stalls, the timeout
   // boundary, reset in the middle of a store and the ERR lock-up.
   initial begin
      outs_t e;
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      opcode    = 4'd0;
      zero      = 1'b0;

      applyStimulus("reset", 1'b0, 1'b0, 4'd0, 1'b0, fetchOuts(1'b0));
      applyStimulus("reset", 1'b0, 1'b0, 4'd0, 1'b0, fetchOuts(1'b0));

      runAlu("add",  4'd0, 0, 1'b0, 4'b0000, 1'b1);
      runAlu("addi", 4'd1, 0, 1'b1, 4'b0000, 1'b0);
      runAlu("sub",  4'd2, 0, 1'b0, 4'b0001, 1'b1);
      runAlu("and",  4'd3, 0, 1'b0, 4'b0010, 1'b1);
      runAlu("or",   4'd4, 0, 1'b0, 4'b0100, 1'b1);
      runAlu("xor",  4'd5, 0, 1'b0, 4'b0110, 1'b1);
      runAlu("not",  4'd6, 0, 1'b0, 4'b1110, 1'b1);
      runAlu("slt",  4'd7, 0, 1'b0, 4'b0111, 1'b1);
      runAlu("lsl",  4'd8, 0, 1'b0, 4'b1100, 1'b1);
      runAlu("lsr",  4'd9, 0, 1'b0, 4'b1000, 1'b1);

      runLdr("ldrWait3", 3);
      runLdr("ldr", 0);
      runStr("str");

      runBranch("beqTaken",  4'd15, 1'b1, 1'b1, 2'b01, 1'b0, 4'b0001);
      runBranch("beqNot",    4'd15, 1'b0, 1'b0, 2'b01, 1'b0, 4'b0001);
      runBranch("bl",        4'd13, 1'b0, 1'b1, 2'b01, 1'b1, 4'b0000);
      runBranch("br",        4'd14, 1'b0, 1'b1, 2'b10, 1'b0, 4'b0000);
      runBranch("b",         4'd12, 1'b0, 1'b1, 2'b01, 1'b0, 4'b0000);

      // Ready arrives in the 15th stalled cycle: no fault, fetch completes.
      runAlu("addWait14", 4'd0, 14, 1'b0, 4'b0000, 1'b1);

      // Reset asserted while a store is waiting in MEM.
      fetchPhase("strRst", 4'd11, 0, 1'b0);
      applyStimulus("strRst/dec", 1'b1, 1'b1, 4'd11, 1'b0, '0);
      e = '0;
      e.aluSrc = 1'b1;
      applyStimulus("strRst/exe", 1'b1, 1'b1, 4'd11, 1'b0, e);
      e.memReq   = 1'b1;
      e.memSel   = 1'b1;
      e.memWrite = 1'b1;
      applyStimulus("strRst/mwait", 1'b1, 1'b0, 4'd11, 1'b0, e);
      expRetire = 0;
      applyStimulus("strRst/rst", 1'b0, 1'b0, 4'd11, 1'b0, fetchOuts(1'b0));
      runAlu("addAfterRst", 4'd0, 0, 1'b0, 4'b0000, 1'b1);

      // Fifteen stalled fetch cycles trip the timeout; ERR holds until reset.
      for (int i = 0; i < 15; i++) begin
         applyStimulus("toWait", 1'b1, 1'b0, 4'd0, 1'b0, fetchOuts(1'b0));
      end
      e = '0;
      e.fault = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus("err", 1'b1, 1'b1, 4'd0, 1'b0, e);
      end
      expRetire = 0;
      applyStimulus("errRst", 1'b0, 1'b0, 4'd0, 1'b0, fetchOuts(1'b0));
      runAlu("addAfterErr", 4'd0, 0, 1'b0, 4'b0000, 1'b1);
      applyStimulus("idleFetch", 1'b1, 1'b0, 4'd0, 1'b0, fetchOuts(1'b0));

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
